// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and bus addresses for the sprite DMA engine; also used by the PPU/bus decoder.
`timescale 1ns/1ps
package oam_dma_ctrl_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN_DEF  = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine and CPU/DMA bus mux.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN (holds ALIGN so the first READ falls on an even cycle).
`timescale 1ns/1ps
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = oam_dma_ctrl_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = oam_dma_ctrl_pkg::OAM_DATA_ADDR,
    parameter int          XFER_LEN      = oam_dma_ctrl_pkg::XFER_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic        cpu_halt,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic        dma_active
);
    import oam_dma_ctrl_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic       trigger;
    logic       align_done;

    assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    // Leave ALIGN only when the following cycle is even, so the first READ is a get cycle.
    assign align_done = parity;
`else
    assign align_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DMA_IDLE;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
            page       <= '0;
            idx        <= '0;
        end else begin
            case (state)
                DMA_ALIGN: begin
                    if (align_done) begin
                        state <= DMA_READ;
                    end
                end
                DMA_READ: begin
                    state <= DMA_WRITE;
                end
                DMA_WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        state      <= DMA_IDLE;
                        cpu_halt   <= 1'b0;
                        dma_active <= 1'b0;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= DMA_READ;
                    end
                end
                default: begin
                    if (trigger) begin
                        page       <= cpu_wdata;
                        idx        <= '0;
                        state      <= DMA_ALIGN;
                        cpu_halt   <= 1'b1;
                        dma_active <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read data is held for the following WRITE cycle only.
    always_ff @(posedge clk) begin
        if (state == DMA_READ) begin
            data_q <= bus_rdata;
        end
    end

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_read  = cpu_read;
        bus_write = cpu_write;
        case (state)
            DMA_ALIGN: begin
                bus_read  = 1'b0;
                bus_write = 1'b0;
            end
            DMA_READ: begin
                bus_addr  = {page, idx};
                bus_read  = 1'b1;
                bus_write = 1'b0;
            end
            DMA_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = data_q;
                bus_read  = 1'b0;
                bus_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: bus accesses checked against a queue of expected accesses.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_halt;
    logic [7:0]  bus_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic        dma_active;

    int   tests    = 0;
    int   failures = 0;
    int   cyc      = 0;
    acc_t exp_q[$];

    oam_dma_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_halt   (cpu_halt),
        .bus_rdata  (bus_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    // Memory model: every location returns its low address byte XOR 5A.
    assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

    // Cycle parity as seen by the design: even on the first cycle after reset.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        acc_t e;
        e.rd = rd; e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_xfer(input logic [7:0] pg, input int n_rd, input int n_wr);
        for (int k = 0; k < n_rd; k++) begin
            logic [7:0] lo;
            lo = 8'(k);
            push(1'b1, 1'b0, {pg, lo}, 8'h00);
            if (k < n_wr) push(1'b0, 1'b1, 16'h2004, lo ^ 8'h5A);
        end
    endtask

    // Scoreboard: every bus strobe must match the next expected access.
    always @(negedge clk) begin
        if (bus_read === 1'b1 || bus_write === 1'b1) begin
            acc_t got;
            acc_t exp;
            got = {bus_read, bus_write, bus_addr, (bus_write === 1'b1) ? bus_wdata : 8'h00};
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("bus_access", 32'(got), 32'(exp));
        end
    end

    // Called at posedge+1; presents the $4014 write on a cycle of the requested parity.
    task automatic start_dma(input logic [7:0] pg, input bit odd);
        while (cyc[0] != odd) begin
            @(posedge clk); #1;
        end
        cpu_addr  = 16'h4014;
        cpu_wdata = pg;
        cpu_write = 1'b1;
        push(1'b0, 1'b1, 16'h4014, pg);
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic measure(input string tag, input int exp_len, output int first_par);
        int n;
        n = 0;
        first_par = -1;
        while (cpu_halt === 1'b1 && n < 600) begin
            if (bus_read === 1'b1 && first_par < 0) first_par = cyc & 1;
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_halt_len"}, 32'(n), 32'(exp_len));
        check({tag, "_active_low"}, {31'd0, dma_active}, 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int par;
        rst       = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h00;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        check("reset_halt", {31'd0, cpu_halt}, 32'd0);
        check("reset_active", {31'd0, dma_active}, 32'd0);
        check("reset_addr_pass", {16'd0, bus_addr}, 32'h1234);
        rst = 1'b0;
        cpu_addr = 16'h0000;

        // Full transfer from page $02 triggered on an even cycle
        start_dma(8'h02, 1'b0);
        push_xfer(8'h02, 256, 256);
        measure("page02", 513, par);
        check("page02_first_read_par", 32'(par), 32'd0);

        // Trigger on an odd cycle
        repeat (3) begin @(posedge clk); #1; end
        start_dma(8'h05, 1'b1);
        push_xfer(8'h05, 256, 256);
`ifdef OAM_DMA_ODD_ALIGN_EN
        measure("odd", 514, par);
        check("odd_first_read_par", 32'(par), 32'd0);
`else
        measure("odd", 513, par);
        check("odd_first_read_par", 32'(par), 32'd1);
`endif

        // Near-miss addresses do not start a transfer
        cpu_addr = 16'h4015; cpu_wdata = 8'h02; cpu_write = 1'b1;
        push(1'b0, 1'b1, 16'h4015, 8'h02);
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_addr = 16'h4014; cpu_read = 1'b1;
        push(1'b1, 1'b0, 16'h4014, 8'h00);
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check("nodma_halt", {31'd0, cpu_halt}, 32'd0);
            @(posedge clk); #1;
        end
        check("nodma_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while byte 100 is being read
        start_dma(8'h04, 1'b0);
        push_xfer(8'h04, 101, 100);
        repeat (201) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_halt", {31'd0, cpu_halt}, 32'd0);
        check("midrst_active", {31'd0, dma_active}, 32'd0);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        start_dma(8'h03, 1'b0);
        push_xfer(8'h03, 256, 256);
        measure("page03", 513, par);

        // Top page: last read at $FFFF, nothing afterwards
        start_dma(8'hFF, 1'b0);
        push_xfer(8'hFF, 256, 256);
        measure("pageFF", 513, par);
        repeat (3) begin @(posedge clk); #1; end
        cpu_addr = 16'h0ABC;
        #1;
        check("pageFF_idle_pass", {16'd0, bus_addr}, 32'h0ABC);
        check("pageFF_queue_final", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
